// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive-path constants.
// Word width and framing agreed by the receiver and its FIFO.
package uart_rx_fifo_pkg;

    localparam int DATA_BITS_DEF = 8;
    localparam int DEPTH_DEF     = 16;
    localparam int START_BITS    = 1;
    localparam int STOP_BITS     = 1;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// First-word-fall-through valid/ready stream.
// master drives out_valid/out_data; slave drives out_ready.
interface uart_rx_fifo_if #(
    parameter int WIDTH = 8
);

    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );

endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Synchronous FWFT FIFO with wrap-bit pointers.
// Ports: push/wdata in, pop in, rdata/full/empty/count out.
module uart_rx_fifo_sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              pop,
    output logic [WIDTH-1:0]  rdata,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] PTR_ONE = 1;

    logic [ADDR_W:0]  wr_ptr;
    logic [ADDR_W:0]  rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[ADDR_W-1:0]];

    // A full FIFO still takes a write when the head leaves
    // in the same cycle: the freed slot is the one written.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[ADDR_W-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: ready-edge capture, FIFO, drop flag.
// Ports: rx_ready/rx_data in, out stream, count/full/empty/overflow.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DATA_BIT_COUNT = DATA_BITS_DEF,
    parameter int DEPTH          = DEPTH_DEF,
    localparam int ADDR_W        = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rx_ready,
    input  logic [DATA_BIT_COUNT-1:0] rx_data,
    uart_rx_fifo_if.master            out,
    output logic [ADDR_W:0]           count,
    output logic                      full,
    output logic                      empty,
    output logic                      overflow,
    input  logic                      overflow_clr
);

    logic rx_ready_q;
    logic push;
    logic pop;
    logic drop;

    // Resets high so a ready level already up at
    // release is not mistaken for a new byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rx_ready_q <= 1'b1;
        else
            rx_ready_q <= rx_ready;
    end

    assign push = rx_ready & ~rx_ready_q;
    assign pop  = ~empty & out.out_ready;
    assign drop = push & full & ~pop;

    assign out.out_valid = ~empty;

    uart_rx_fifo_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_BIT_COUNT)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (rx_data),
        .pop   (pop),
        .rdata (out.out_data),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
        else if (overflow_clr)
            overflow <= 1'b0;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo.
// Drives and samples on the falling clock edge.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       overflow_clr;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       overflow;

    uart_rx_fifo_if #(.WIDTH(8)) bus ();

    uart_rx_fifo dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .out          (bus.master),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    logic [7:0] sb [$];
    bit         exp_ovf;
    int         checks;
    int         errors;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h",
                     tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        int n;
        n = sb.size();
        chk({tag, ".count"}, 32'(count), n);
        chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
        chk({tag, ".full"}, 32'(full), 32'(n == 16));
        chk({tag, ".valid"}, 32'(bus.out_valid),
            32'(n != 0));
        chk({tag, ".ovf"}, 32'(overflow), 32'(exp_ovf));
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        tick();
        if (sb.size() < 16)
            sb.push_back(b);
        else
            exp_ovf = 1'b1;
    endtask

    task automatic pop_one(input string tag);
        logic [7:0] e;
        if (sb.size() == 0) begin
            chk({tag, ".sb"}, 32'(bus.out_valid), 0);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".valid"}, 32'(bus.out_valid), 1);
        chk({tag, ".data"}, 32'(bus.out_data), 32'(e));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, ".cnt"}, 32'(count), sb.size());
    endtask

    task automatic drain(input string tag);
        while (sb.size() > 0)
            pop_one(tag);
        check_state({tag, ".end"});
    endtask

    task automatic fill(input logic [7:0] base);
        for (int i = 0; i < 16; i++)
            push_byte(base + 8'(i));
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        exp_ovf       = 1'b0;
        rst_n         = 1'b0;
        rx_ready      = 1'b1;
        rx_data       = 8'h3C;
        overflow_clr  = 1'b0;
        bus.out_ready = 1'b0;

        // 1: ready high across reset release
        #12;
        tick();
        rst_n = 1'b1;
        repeat (20) tick();
        check_state("t1");
        rx_ready = 1'b0;
        tick();
        check_state("t1b");

        // 2: long ready level gives one entry
        rx_data  = 8'hA5;
        rx_ready = 1'b1;
        tick();
        chk("t2.valid", 32'(bus.out_valid), 1);
        chk("t2.data", 32'(bus.out_data), 32'hA5);
        chk("t2.cnt1", 32'(count), 1);
        repeat (4) tick();
        rx_ready = 1'b0;
        tick();
        sb.push_back(8'hA5);
        check_state("t2");
        drain("t2d");

        // 3: fill, drop one, drain in order
        fill(8'h00);
        check_state("t3f");
        push_byte(8'h10);
        check_state("t3o");
        drain("t3d");
        bus.out_ready = 1'b1;
        repeat (2) tick();
        bus.out_ready = 1'b0;
        check_state("t3u");
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        exp_ovf = 1'b0;
        check_state("t3c");

        // 4: push and pop together while full
        fill(8'h20);
        check_state("t4f");
        chk("t4.head", 32'(bus.out_data), 32'(sb[0]));
        void'(sb.pop_front());
        sb.push_back(8'h30);
        rx_data       = 8'h30;
        rx_ready      = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        rx_ready      = 1'b0;
        bus.out_ready = 1'b0;
        check_state("t4s");
        drain("t4d");

        // 5: set beats clear
        fill(8'h40);
        push_byte(8'h50);
        check_state("t5o");
        rx_data      = 8'h51;
        rx_ready     = 1'b1;
        overflow_clr = 1'b1;
        tick();
        rx_ready     = 1'b0;
        overflow_clr = 1'b0;
        tick();
        check_state("t5s");
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        exp_ovf = 1'b0;
        check_state("t5c");
        drain("t5d");

        // 6: async reset mid-stream
        for (int i = 0; i < 7; i++)
            push_byte(8'h60 + 8'(i));
        check_state("t6p");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        exp_ovf = 1'b0;
        check_state("t6r");
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check_state("t6a");
        push_byte(8'h77);
        check_state("t6n");
        drain("t6d");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
